// File: rtl/fifo_pkg.sv
// Purpose: shared constants and helpers for the FIFO pointer/flag controller.
// Latency: n/a (compile-time definitions only).
// Backpressure: n/a.
// Contents: cnt_width() sizes the occupancy counter; PTR_RST is the pointer reset value.
package fifo_pkg;

  // Pointer value after reset and after a synchronous flush.
  localparam int PTR_RST = 0;

  // Occupancy must represent 0..depth inclusive. depth can equal 2**addr,
  // so the counter needs one more bit than the address.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Purpose: wrapping RAM address pointer (depth need not be a power of two).
// Latency: o_ptr advances at the clock edge following i_inc.
// Backpressure: none; the caller only asserts i_inc for accepted transfers.
// Ports: Clock, Reset_n (async active-low), i_clr (sync flush, wins over i_inc),
//        i_inc (advance by one), o_ptr (current address).
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int depth = 8,
  parameter int addr  = 3
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            i_clr,
  input  logic            i_inc,
  output logic [addr-1:0] o_ptr
);

  localparam logic [addr-1:0] PTR_LAST = addr'(depth - 1);
  localparam logic [addr-1:0] PTR_ZERO = addr'(PTR_RST);

  logic [addr-1:0] r_ptr;

  // Wrap by explicit compare so a non-power-of-two depth never touches
  // addresses beyond depth-1.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ptr <= PTR_ZERO;
    end else if (i_clr) begin
      r_ptr <= PTR_ZERO;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == PTR_LAST) ? PTR_ZERO : r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Purpose: pointer/flag controller driving an external dual-port register RAM as a FIFO.
// Latency: WE/RE combinational from Push/Pop; RdValid one cycle after an accepted pop.
// Backpressure: push rejected while Full, pop rejected while Empty; Clear blocks both.
// Ports: Clock, Reset_n (async active-low), Clear (sync flush), Push, Pop,
//        WE/RE/WAddress/RAddress to the RAM, Full, Empty, Count, RdValid.
// Optional: FIFO_ERR_FLAGS_EN adds sticky Overflow/Underflow outputs.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int depth = 8,
  parameter int addr  = 3
) (
  input  logic                        Clock,
  input  logic                        Reset_n,
  input  logic                        Clear,
  input  logic                        Push,
  input  logic                        Pop,
  output logic                        WE,
  output logic                        RE,
  output logic [addr-1:0]             WAddress,
  output logic [addr-1:0]             RAddress,
  output logic                        Full,
  output logic                        Empty,
  output logic [cnt_width(addr)-1:0]  Count,
  output logic                        RdValid
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                        Overflow,
  output logic                        Underflow
`endif
);

  localparam int CW = cnt_width(addr);
  localparam logic [CW-1:0] CNT_FULL = CW'(depth);

  logic [CW-1:0] r_count;
  logic          r_rdvalid;
  logic [CW-1:0] w_count_nxt;
  logic          w_full;
  logic          w_empty;
  logic          w_we;
  logic          w_re;

  // Flags come only from the registered count, so they never glitch with
  // Push/Pop. Push is refused when full even if a pop is also requested,
  // avoiding a same-edge read and write of one address.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_we    = Push & ~w_full  & ~Clear;
  assign w_re    = Pop  & ~w_empty & ~Clear;

  fifo_ptr #(.depth(depth), .addr(addr)) u_wptr (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .i_clr   (Clear),
    .i_inc   (w_we),
    .o_ptr   (WAddress)
  );

  fifo_ptr #(.depth(depth), .addr(addr)) u_rptr (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .i_clr   (Clear),
    .i_inc   (w_re),
    .o_ptr   (RAddress)
  );

  always_comb begin
    w_count_nxt = r_count;
    if (w_we && !w_re) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_re && !w_we) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // w_re is already forced low by Clear, so RdValid needs no separate flush term.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_count   <= '0;
      r_rdvalid <= 1'b0;
    end else if (Clear) begin
      r_count   <= '0;
      r_rdvalid <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_rdvalid <= w_re;
    end
  end

  assign WE      = w_we;
  assign RE      = w_re;
  assign Full    = w_full;
  assign Empty   = w_empty;
  assign Count   = r_count;
  assign RdValid = r_rdvalid;

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Sticky error flags; a Clear in the same cycle as an error wins.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (Clear) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (Push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (Pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;
`else
  // Error flags not built: no extra state or ports.
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Purpose: self-checking bench for fifo_ctrl (depth=8, addr=3) with a behavioural 8x8 RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_ctrl;

  logic       Clock;
  logic       Reset_n;
  logic       Clear;
  logic       Push;
  logic       Pop;
  logic       WE;
  logic       RE;
  logic [2:0] WAddress;
  logic [2:0] RAddress;
  logic       Full;
  logic       Empty;
  logic [3:0] Count;
  logic       RdValid;
`ifdef FIFO_ERR_FLAGS_EN
  logic       Overflow;
  logic       Underflow;
`endif

  logic [7:0] wdat;
  logic [7:0] mem [0:7];
  logic [7:0] q;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_ctrl #(.depth(8), .addr(3)) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Clear    (Clear),
    .Push     (Push),
    .Pop      (Pop),
    .WE       (WE),
    .RE       (RE),
    .WAddress (WAddress),
    .RAddress (RAddress),
    .Full     (Full),
    .Empty    (Empty),
    .Count    (Count),
    .RdValid  (RdValid)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .Overflow (Overflow),
    .Underflow(Underflow)
`endif
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Behavioural RAM with registered read data.
  always @(posedge Clock) begin
    if (WE) mem[WAddress] <= wdat;
    if (RE) q <= mem[RAddress];
  end

  typedef struct {
    logic        clr;
    logic        push;
    logic        pop;
    logic [7:0]  wdat;
    logic [14:0] exp;
    logic        chk_q;
    logic [7:0]  exp_q;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];

  // {WE, RE, WAddress, RAddress, Count, Full, Empty, RdValid}
  function automatic logic [14:0] pk(input logic we, input logic re, input int wa,
                                     input int ra, input int cnt, input logic rv);
    logic full;
    logic empty;
    full  = (cnt == 8);
    empty = (cnt == 0);
    return {we, re, 3'(wa), 3'(ra), 4'(cnt), full, empty, rv};
  endfunction

  task automatic add(input logic clr, input logic push, input logic pop, input logic [7:0] wd,
                     input logic we, input logic re, input int wa, input int ra, input int cnt,
                     input logic rv, input logic chk_q, input logic [7:0] exp_q,
                     input logic ovf, input logic unf);
    vec_t v;
    v.clr = clr; v.push = push; v.pop = pop; v.wdat = wd;
    v.exp = pk(we, re, wa, ra, cnt, rv);
    v.chk_q = chk_q; v.exp_q = exp_q; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    Reset_n = 1'b0; Clear = 1'b0; Push = 1'b0; Pop = 1'b0; wdat = 8'h00;

    // Idle after reset.
    add(0,0,0,0,    0,0,0,0,0,0, 0,0, 0,0);
    // Fill: WAddress 0..7.
    for (int i = 0; i < 8; i++) add(0,1,0,8'(8'hA0 + i), 1,0,i,0,i,0, 0,0, 0,0);
    // Push while full: rejected; overflow sticks from the next cycle.
    add(0,1,0,8'hEE, 0,0,0,0,8,0, 0,0, 0,0);
    add(0,1,0,8'hEE, 0,0,0,0,8,0, 0,0, 1,0);
    // Drain: RAddress 0..7, data back in write order one cycle later.
    for (int i = 0; i < 8; i++) add(0,0,1,0, 0,1,0,i,8-i,(i > 0), (i > 0), 8'(8'hA0 + i - 1), 1,0);
    add(0,0,0,0,    0,0,0,0,0,1, 1,8'hA7, 1,0);
    // Push+pop while empty: push only, underflow sticks.
    add(0,1,1,8'h55, 1,0,0,0,0,0, 0,0, 1,0);
    add(0,0,0,0,    0,0,1,0,1,0, 0,0, 1,1);
    // Build up to count 3.
    add(0,1,0,8'h01, 1,0,1,0,1,0, 0,0, 1,1);
    add(0,1,0,8'h02, 1,0,2,0,2,0, 0,0, 1,1);
    // Push+pop at count 3 for 10 cycles: both pointers wrap.
    for (int i = 0; i < 10; i++) add(0,1,1,8'h10, 1,1,(3 + i) % 8,i % 8,3,(i > 0), 0,0, 1,1);
    // Fill to 8.
    for (int i = 0; i < 5; i++) add(0,1,0,8'h20, 1,0,(5 + i) % 8,2,3 + i,(i == 0), 0,0, 1,1);
    // Push+pop while full: pop only.
    add(0,1,1,8'h30, 0,1,2,2,8,0, 0,0, 1,1);
    add(0,0,0,0,    0,0,2,3,7,1, 0,0, 1,1);
    // Pop down to 5, then Clear with push and pop requested.
    add(0,0,1,0,    0,1,2,3,7,0, 0,0, 1,1);
    add(0,0,1,0,    0,1,2,4,6,1, 0,0, 1,1);
    add(1,1,1,8'h40, 0,0,2,5,5,1, 0,0, 1,1);
    add(0,0,0,0,    0,0,0,0,0,0, 0,0, 0,0);

    // Asynchronous reset state before any clock edge.
    #1;
    chk("reset_state", 32'({WE, RE, WAddress, RAddress, Count, Full, Empty, RdValid}),
        32'(pk(0,0,0,0,0,0)));
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clock);
      Clear = vecs[i].clr; Push = vecs[i].push; Pop = vecs[i].pop; wdat = vecs[i].wdat;
      #1;
      chk($sformatf("vec%0d", i),
          32'({WE, RE, WAddress, RAddress, Count, Full, Empty, RdValid}), 32'(vecs[i].exp));
      if (vecs[i].chk_q) chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
`ifdef FIFO_ERR_FLAGS_EN
      chk($sformatf("vec%0d_flags", i), 32'({Overflow, Underflow}),
          32'({vecs[i].ovf, vecs[i].unf}));
`endif
    end

    // Reset pulse with a read in flight: RdValid drops without a clock edge.
    @(negedge Clock);
    Clear = 1'b0; Push = 1'b1; Pop = 1'b0; wdat = 8'hB0;
    @(negedge Clock);
    wdat = 8'hB1;
    @(negedge Clock);
    Push = 1'b0; Pop = 1'b1;
    @(negedge Clock);
    Pop = 1'b0;
    #1;
    chk("inflight_rdvalid", 32'(RdValid), 32'd1);
    chk("inflight_q", 32'(q), 32'hB0);
    chk("inflight_count", 32'(Count), 32'd1);
    #1;
    Reset_n = 1'b0;
    #1;
    chk("async_rst_rdvalid", 32'(RdValid), 32'd0);
    chk("async_rst_state", 32'({Count, Empty, Full, WAddress, RAddress}),
        32'({4'd0, 1'b1, 1'b0, 3'd0, 3'd0}));
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    #1;
    chk("post_rst_idle", 32'({WE, RE, Count, Empty}), 32'({1'b0, 1'b0, 4'd0, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
